// File: rtl/apb_fsm_controller.sv
// APB setup/enable sequencer for the AHB-to-APB bridge; optional `APB_PREADY_EN adds a Pready input.
// Latency: read setup 1 cycle after the AHB address phase, write setup 2 cycles after (waits for data).
// Backpressure: Hreadyout low during read setup, pipelined write setup, and while Pready is low (APB_PREADY_EN).
module apb_fsm_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [ADDR_W-1:0] Haddr1,
    input  logic [ADDR_W-1:0] Haddr2,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Hwdata1,
    input  logic              Hwrite,
    input  logic              Hwritereg,
    input  logic [NSLV-1:0]   tempselx,
`ifdef APB_PREADY_EN
    input  logic              Pready,
`endif
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_WRITE,
        ST_WRITEP,
        ST_RENABLE,
        ST_WENABLE,
        ST_WENABLEP
    } state_t;

    state_t              state_q;
    logic [NSLV-1:0]     selx1_q;
    logic [NSLV-1:0]     selx2_q;
    logic [NSLV-1:0]     pselx_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                hreadyout_q;
    logic                pready_w;

`ifdef APB_PREADY_EN
    assign pready_w = Pready;
`else
    assign pready_w = 1'b1;
`endif

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q     <= ST_IDLE;
            selx1_q     <= '0;
            selx2_q     <= '0;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            selx1_q <= tempselx;
            selx2_q <= selx1_q;
            case (state_q)
                ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                    if (state_q != ST_IDLE && !pready_w) begin
                        hreadyout_q <= 1'b0;
                    end else if (valid && !Hwrite) begin
                        state_q     <= ST_READ;
                        pselx_q     <= tempselx;
                        paddr_q     <= Haddr;
                        pwrite_q    <= 1'b0;
                        penable_q   <= 1'b0;
                        hreadyout_q <= 1'b0;
                    end else begin
                        state_q     <= valid ? ST_WWAIT : ST_IDLE;
                        pselx_q     <= '0;
                        penable_q   <= 1'b0;
                        hreadyout_q <= 1'b1;
                    end
                end
                // Write data arrives one cycle after its address, so setup uses the delayed address/select.
                ST_WWAIT: begin
                    state_q     <= valid ? ST_WRITEP : ST_WRITE;
                    pselx_q     <= selx1_q;
                    paddr_q     <= Haddr1;
                    pwdata_q    <= Hwdata;
                    pwrite_q    <= 1'b1;
                    penable_q   <= 1'b0;
                    hreadyout_q <= !valid;
                end
                ST_READ: begin
                    state_q     <= ST_RENABLE;
                    penable_q   <= 1'b1;
                    hreadyout_q <= 1'b1;
                end
                ST_WRITE: begin
                    state_q     <= valid ? ST_WENABLEP : ST_WENABLE;
                    penable_q   <= 1'b1;
                    hreadyout_q <= 1'b1;
                end
                ST_WRITEP: begin
                    state_q     <= ST_WENABLEP;
                    penable_q   <= 1'b1;
                    hreadyout_q <= 1'b1;
                end
                ST_WENABLEP: begin
                    if (!pready_w) begin
                        hreadyout_q <= 1'b0;
                    end else if (!Hwritereg) begin
                        state_q     <= ST_READ;
                        pselx_q     <= tempselx;
                        paddr_q     <= Haddr;
                        pwrite_q    <= 1'b0;
                        penable_q   <= 1'b0;
                        hreadyout_q <= 1'b0;
                    end else begin
                        // The pipelined write's address is now two cycles old.
                        state_q     <= valid ? ST_WRITEP : ST_WRITE;
                        pselx_q     <= selx2_q;
                        paddr_q     <= Haddr2;
                        pwdata_q    <= Hwdata1;
                        pwrite_q    <= 1'b1;
                        penable_q   <= 1'b0;
                        hreadyout_q <= !valid;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    pselx_q     <= '0;
                    penable_q   <= 1'b0;
                    hreadyout_q <= 1'b1;
                end
            endcase
        end
    end

    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: directed scenarios plus a randomized run against a transaction-level model.
module tb_apb_fsm_controller;

    logic        Hclk = 1'b0;
    logic        Hreset = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] Haddr = '0, Haddr1 = '0, Haddr2 = '0;
    logic [31:0] Hwdata = '0, Hwdata1 = '0;
    logic        Hwrite = 1'b0, Hwritereg = 1'b0;
    logic [2:0]  tempselx = '0;
`ifdef APB_PREADY_EN
    logic        Pready = 1'b1;
`endif
    logic [2:0]  Pselx;
    logic        Penable, Pwrite, Hreadyout;
    logic [31:0] Paddr, Pwdata;

    int checks = 0;
    int errors = 0;

    apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .valid(valid),
        .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2),
        .Hwdata(Hwdata), .Hwdata1(Hwdata1),
        .Hwrite(Hwrite), .Hwritereg(Hwritereg), .tempselx(tempselx),
`ifdef APB_PREADY_EN
        .Pready(Pready),
`endif
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Hreadyout(Hreadyout)
    );

    always #5 Hclk = ~Hclk;

    // Reference model: named phases and the values the APB bus should carry.
    string       m_st = "IDLE";
    logic [2:0]  m_psel = '0, m_s1 = '0, m_s2 = '0;
    logic        m_pen = 1'b0, m_pwr = 1'b0, m_rdy = 1'b1;
    logic [31:0] m_paddr = '0, m_pwd = '0;

    function automatic logic [2:0] dec(input logic [31:0] a);
        case (a[31:24])
            8'h80:   return 3'b001;
            8'h84:   return 3'b010;
            8'h88:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit is_en(input string s);
        return (s == "RENABLE") || (s == "WENABLE") || (s == "WENABLEP");
    endfunction

    function automatic string next_phase(input string s, input logic v, input logic w, input logic wr);
        if (s == "WWAIT")    return v ? "WRITEP" : "WRITE";
        if (s == "READ")     return "RENABLE";
        if (s == "WRITE")    return v ? "WENABLEP" : "WENABLE";
        if (s == "WRITEP")   return "WENABLEP";
        if (s == "WENABLEP") return !wr ? "READ" : (v ? "WRITEP" : "WRITE");
        return !v ? "IDLE" : (w ? "WWAIT" : "READ");
    endfunction

    task automatic model_step();
        string prev, nxt;
        bit hold;
        if (Hreset) begin
            m_st = "IDLE"; m_psel = '0; m_pen = 1'b0; m_pwr = 1'b0;
            m_paddr = '0; m_pwd = '0; m_rdy = 1'b1; m_s1 = '0; m_s2 = '0;
            return;
        end
        prev = m_st;
        hold = 1'b0;
`ifdef APB_PREADY_EN
        hold = is_en(prev) && !Pready;
`endif
        if (hold) begin
            m_rdy = 1'b0;
        end else begin
            nxt = next_phase(prev, valid, Hwrite, Hwritereg);
            if (nxt == "IDLE" || nxt == "WWAIT") begin
                m_psel = '0; m_pen = 1'b0; m_rdy = 1'b1;
            end else if (nxt == "READ") begin
                m_psel = tempselx; m_paddr = Haddr; m_pwr = 1'b0; m_pen = 1'b0; m_rdy = 1'b0;
            end else if (is_en(nxt)) begin
                m_pen = 1'b1; m_rdy = 1'b1;
            end else begin
                if (prev == "WWAIT") begin
                    m_psel = m_s1; m_paddr = Haddr1; m_pwd = Hwdata;
                end else begin
                    m_psel = m_s2; m_paddr = Haddr2; m_pwd = Hwdata1;
                end
                m_pwr = 1'b1; m_pen = 1'b0; m_rdy = (nxt == "WRITE");
            end
            m_st = nxt;
        end
        m_s2 = m_s1;
        m_s1 = tempselx;
    endtask

    task automatic cyc(input logic rst, input logic v, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        Haddr2 = Haddr1; Haddr1 = Haddr; Haddr = a;
        Hwdata1 = Hwdata; Hwdata = d;
        Hwritereg = Hwrite; Hwrite = w;
        valid = v; tempselx = dec(a); Hreset = rst;
        @(posedge Hclk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom);
        checks++;
        if ({Pselx, Penable, Pwrite, Hreadyout} !== 6'b000_0_0_1) begin
            errors++; $display("FAIL reset_ctrl: got %b required %b", {Pselx, Penable, Pwrite, Hreadyout}, 6'b000001);
        end
        checks++;
        if ({Paddr, Pwdata} !== 64'h0) begin
            errors++; $display("FAIL reset_bus: got %h required 0", {Paddr, Pwdata});
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_single_read();
        cyc(1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
        checks++;
        if ({Pselx, Penable, Pwrite, Hreadyout, Paddr} !== {3'b001, 1'b0, 1'b0, 1'b0, 32'h8000_0010}) begin
            errors++; $display("FAIL read_setup: got %b/%h required 001000/80000010", {Pselx, Penable, Pwrite, Hreadyout}, Paddr);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({Pselx, Penable, Hreadyout, Paddr} !== {3'b001, 1'b1, 1'b1, 32'h8000_0010}) begin
            errors++; $display("FAIL read_enable: got %b/%h required 00111/80000010", {Pselx, Penable, Hreadyout}, Paddr);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1) begin
            errors++; $display("FAIL read_idle: got %b required 00001", {Pselx, Penable, Hreadyout});
        end
    endtask

    task automatic test_single_write();
        cyc(1'b0, 1'b1, 1'b1, 32'h8400_0004, 32'h0);
        checks++;
        if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1) begin
            errors++; $display("FAIL write_wait: got %b required 00001", {Pselx, Penable, Hreadyout});
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
        checks++;
        if ({Pselx, Penable, Pwrite, Hreadyout, Paddr, Pwdata} !== {3'b010, 1'b0, 1'b1, 1'b1, 32'h8400_0004, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL write_setup: got %b/%h/%h required 010011/84000004/deadbeef", {Pselx, Penable, Pwrite, Hreadyout}, Paddr, Pwdata);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({Pselx, Penable, Pwrite, Pwdata} !== {3'b010, 1'b1, 1'b1, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL write_enable: got %b/%h required 01011/deadbeef", {Pselx, Penable, Pwrite}, Pwdata);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        cyc(1'b0, 1'b1, 1'b1, 32'h8800_0000, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 32'h8800_0004, 32'h11);
        checks++;
        if ({Pselx, Penable, Hreadyout, Paddr, Pwdata} !== {3'b100, 1'b0, 1'b0, 32'h8800_0000, 32'h11}) begin
            errors++; $display("FAIL b2b_first_setup: got %b/%h/%h required 10000/88000000/11", {Pselx, Penable, Hreadyout}, Paddr, Pwdata);
        end
        cyc(1'b0, 1'b1, 1'b1, 32'h8800_0004, 32'h22);
        checks++;
        if ({Penable, Hreadyout, Paddr} !== {1'b1, 1'b1, 32'h8800_0000}) begin
            errors++; $display("FAIL b2b_first_enable: got %b/%h required 11/88000000", {Penable, Hreadyout}, Paddr);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({Pselx, Penable, Pwrite, Paddr, Pwdata} !== {3'b100, 1'b0, 1'b1, 32'h8800_0004, 32'h22}) begin
            errors++; $display("FAIL b2b_second_setup: got %b/%h/%h required 10001/88000004/22", {Pselx, Penable, Pwrite}, Paddr, Pwdata);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({Penable, Paddr, Pwdata} !== {1'b1, 32'h8800_0004, 32'h22}) begin
            errors++; $display("FAIL b2b_second_enable: got %b/%h/%h required 1/88000004/22", Penable, Paddr, Pwdata);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_write_read();
        cyc(1'b0, 1'b1, 1'b1, 32'h8400_0008, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h8000_0020, 32'h55);
        checks++;
        if ({Pwrite, Hreadyout, Paddr, Pwdata} !== {1'b1, 1'b0, 32'h8400_0008, 32'h55}) begin
            errors++; $display("FAIL wr_rd_write_setup: got %b/%h/%h required 10/84000008/55", {Pwrite, Hreadyout}, Paddr, Pwdata);
        end
        cyc(1'b0, 1'b1, 1'b0, 32'h8000_0020, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h8000_0020, 32'h0);
        checks++;
        if ({Pselx, Penable, Pwrite, Hreadyout, Paddr} !== {3'b001, 1'b0, 1'b0, 1'b0, 32'h8000_0020}) begin
            errors++; $display("FAIL wr_rd_read_setup: got %b/%h required 001000/80000020", {Pselx, Penable, Pwrite, Hreadyout}, Paddr);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        cyc(1'b0, 1'b1, 1'b1, 32'h8400_0000, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h99);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (Penable !== 1'b1) begin
            errors++; $display("FAIL mid_reset_pre: Penable got %b required 1", Penable);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({Pselx, Penable, Hreadyout, Pwdata} !== {3'b000, 1'b0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL mid_reset: got %b/%h required 00001/0", {Pselx, Penable, Hreadyout}, Pwdata);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

`ifdef APB_PREADY_EN
    task automatic test_pready();
        cyc(1'b0, 1'b1, 1'b0, 32'h8000_0030, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        Pready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            checks++;
            if ({Pselx, Penable, Hreadyout} !== 5'b001_1_0) begin
                errors++; $display("FAIL pready_hold[%0d]: got %b required 00110", i, {Pselx, Penable, Hreadyout});
            end
        end
        Pready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1) begin
            errors++; $display("FAIL pready_release: got %b required 00001", {Pselx, Penable, Hreadyout});
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(3))
                0:       a = 32'h8000_0000 | ($urandom & 32'hFFFC);
                1:       a = 32'h8400_0000 | ($urandom & 32'hFFFC);
                2:       a = 32'h8800_0000 | ($urandom & 32'hFFFC);
                default: a = $urandom;
            endcase
`ifdef APB_PREADY_EN
            Pready = ($urandom_range(3) != 0);
`endif
            cyc(($urandom_range(63) == 0), ($urandom_range(2) != 0), 1'($urandom), a, $urandom);
            checks++;
            if ({Pselx, Penable, Pwrite, Hreadyout} !== {m_psel, m_pen, m_pwr, m_rdy}) begin
                errors++; $display("FAIL rand_ctrl@%0d: got %b required %b (phase %s)", n, {Pselx, Penable, Pwrite, Hreadyout}, {m_psel, m_pen, m_pwr, m_rdy}, m_st);
            end
            checks++;
            if ({Paddr, Pwdata} !== {m_paddr, m_pwd}) begin
                errors++; $display("FAIL rand_bus@%0d: got %h/%h required %h/%h (phase %s)", n, Paddr, Pwdata, m_paddr, m_pwd, m_st);
            end
        end
`ifdef APB_PREADY_EN
        Pready = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_write_read();
        test_reset_mid();
`ifdef APB_PREADY_EN
        test_pready();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
